board_level_block_tx_arbiter: RTL

//  Shares one board_level_data_block_transmitter between REQ_N requesters.
//  - Round-robin arbitration; latches the winner's BYTE_N-byte block.
//  - Issues the block to the transmitter with the we/ready handshake.
//  - Waits until the transmitter is ready again before the next grant.
//  - Sits between producer blocks and the transmitter data/we/ready ports.

---
 rtl/board_level_block_tx_arbiter_pkg.sv | 44 ++++
 rtl/board_level_block_tx_arbiter_if.sv | 36 +++
 rtl/board_level_block_tx_arbiter_rr.sv | 50 +++++
 rtl/board_level_block_tx_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/board_level_block_tx_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_level_block_tx_arbiter_pkg : shared widths, state codes, helpers.
// Option macro BLOCK_ARB_CHANNEL_TAG_EN widens tx_data by one tag byte.
// Rev 1.0
// ---------------------------------------------------------------------------
package board_level_block_tx_arbiter_pkg;

  localparam int TAG_BYTE_OFFSET = 0;
  localparam int ID_BYTE_W       = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int id_width(input int req_n);
    return (clog2(req_n) < 1) ? 1 : clog2(req_n);
  endfunction

  function automatic int tx_width(input int byte_n);
`ifdef BLOCK_ARB_CHANNEL_TAG_EN
    return (byte_n + 1) * 8;
`else
    return byte_n * 8;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_level_block_tx_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_level_block_tx_arbiter_if : requester and transmitter side signals.
// Rev 1.0
// ---------------------------------------------------------------------------
interface board_level_block_tx_arbiter_if #(
  parameter int REQ_N  = 4,
  parameter int BYTE_N = 8
);
  import board_level_block_tx_arbiter_pkg::*;

  localparam int ID_W = id_width(REQ_N);
  localparam int TX_W = tx_width(BYTE_N);

  logic [REQ_N-1:0]          req_valid;
  logic [REQ_N*BYTE_N*8-1:0] req_data;
  logic [REQ_N-1:0]          req_ack;
  logic [TX_W-1:0]           tx_data;
  logic                      tx_we;
  logic                      tx_ready;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  // master: producers plus transmitter; slave: the arbiter itself
  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ack, tx_data, tx_we, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ack, tx_data, tx_we, grant_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/board_level_block_tx_arbiter_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_level_rr_arbiter : round-robin pick starting after the last winner.
// Rev 1.0
// ---------------------------------------------------------------------------
module board_level_rr_arbiter
  import board_level_block_tx_arbiter_pkg::*;
#(
  parameter int REQ_N = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_N-1:0]              req_i,
  input  logic                          advance_i,
  output logic [REQ_N-1:0]              grant_o,
  output logic [id_width(REQ_N)-1:0]    grant_idx_o
);

  localparam int ID_W = id_width(REQ_N);

  logic [ID_W-1:0] last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_W'(REQ_N - 1);
    end else if (advance_i) begin
      last_q <= grant_idx_o;
    end
  end

  always_comb begin
    int   cand;
    logic found;
    cand        = 0;
    found       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    // k = REQ_N wraps back to last itself, so a lone repeat requester still wins
    for (int k = 1; k <= REQ_N; k++) begin
      cand = (int'(last_q) + k) % REQ_N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = ID_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_level_block_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_level_block_tx_arbiter : shares one block transmitter among REQ_N
// requesters. Option macro BLOCK_ARB_CHANNEL_TAG_EN prepends a grant-id byte.
// Rev 1.0
// ---------------------------------------------------------------------------
module board_level_block_tx_arbiter
  import board_level_block_tx_arbiter_pkg::*;
#(
  parameter int REQ_N  = 4,
  parameter int BYTE_N = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  board_level_block_tx_arbiter_if.slave bus
);

  localparam int ID_W  = id_width(REQ_N);
  localparam int PAY_W = BYTE_N * 8;

  state_e            state_q, state_d;
  logic [PAY_W-1:0]  hold_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [REQ_N-1:0]  w_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_advance;

  board_level_rr_arbiter #(.REQ_N(REQ_N)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (bus.req_valid),
    .advance_i   (w_advance),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      grant_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_advance) begin
        hold_q     <= bus.req_data[int'(w_grant_idx)*PAY_W +: PAY_W];
        grant_id_q <= w_grant_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.req_ack = '0;
    bus.tx_we   = 1'b0;
    w_advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          bus.req_ack = w_grant;
          w_advance   = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        bus.tx_we = bus.tx_ready;
        if (bus.tx_ready) state_d = DRAIN;
      end
      DRAIN: begin
        // ready drops right after accept and returns at the end of the frame
        if (bus.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.grant_id = grant_id_q;

`ifdef BLOCK_ARB_CHANNEL_TAG_EN
  // tag sits in the low byte so the LSB-first transmitter sends it first
  assign bus.tx_data = {hold_q, ID_BYTE_W'(grant_id_q)};
`else
  assign bus.tx_data = hold_q;
`endif

endmodule
`default_nettype wire
